// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
//   muldiv_state_t : mul/div sequencer states
//   *_DEF          : default latencies and counter width
//   load_use_hazard: ID-stage load-use compare against the load in EX
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } muldiv_state_t;

    localparam int unsigned MUL_LAT_DEF = 4;
    localparam int unsigned DIV_LAT_DEF = 32;
    localparam int unsigned CNT_W_DEF   = 16;

    // Writes to $0 are discarded, so they can never create a dependency.
    function automatic logic load_use_hazard(
        input logic       mem_read,
        input logic [4:0] wn,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rt
    );
        return mem_read && (wn != 5'd0) && ((wn == rs) || (uses_rt && (wn == rt)));
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Multi-cycle mul/div sequencer: holds the pipe while a mul/div sits in EX.
// Ports:
//   clk    in  rising-edge clock
//   abort  in  synchronous abort (reset or redirect): return to IDLE, no done pulse
//   start  in  instruction in EX is mul/div
//   is_div in  1 = divide latency, 0 = multiply latency (sampled at start)
//   busy   out pipe must stall this cycle
//   done   out one-cycle pulse, result valid in EX
//   idle   out sequencer is in IDLE
module muldiv_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic abort,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done,
    output logic idle
);

    localparam int unsigned MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int unsigned CW      = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

    muldiv_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    int unsigned   lat;

    assign lat = is_div ? DIV_LAT : MUL_LAT;

    always_ff @(posedge clk) begin
        if (abort) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The start cycle and the final BUSY cycle (cnt==0) both stall, so a
    // count of LAT-3 yields exactly LAT-1 stall cycles before DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (lat == 32'd2) begin
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CW'(lat - 32'd3);
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = !abort && (((state_q == IDLE) && start) || (state_q == BUSY));
        done = !abort && (state_q == DONE);
        idle = (state_q == IDLE);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Priority: redirect (branch/JAL in MEM) > mul/div freeze > load-use stall.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   id_rs, id_rt, id_uses_rt    source operands of the instruction in ID
//   id_ex_mem_read, id_ex_wn    load in EX and its destination
//   id_ex_muldiv, id_ex_is_div  mul/div in EX and its kind
//   ex_mem_branch/zero/jal      control-flow resolution in MEM
//   pc_en, if_id_en, id_ex_en   stage register load enables
//   *_flush                     stage register clear (bubble)
//   redirect                    PC takes branch/JAL target
//   muldiv_busy, muldiv_done    mul/div stall and completion pulse
//   stall_cnt, flush_cnt        saturating performance counters
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_wn,
    input  logic             id_ex_muldiv,
    input  logic             id_ex_is_div,
    input  logic             ex_mem_branch,
    input  logic             ex_mem_zero,
    input  logic             ex_mem_jal,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             redirect,
    output logic             muldiv_busy,
    output logic             muldiv_done,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic             taken;
    logic             lu_hazard;
    logic             md_busy, md_done, md_idle;
    logic             stall_evt;
    logic [CNT_W-1:0] stall_q, flush_q;

    assign taken     = (ex_mem_branch && ex_mem_zero) || ex_mem_jal;
    assign lu_hazard = load_use_hazard(id_ex_mem_read, id_ex_wn, id_rs, id_rt, id_uses_rt);

    // A redirect kills the mul/div because it is younger than the branch.
    muldiv_seq #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_muldiv_seq (
        .clk    (clk),
        .abort  (rst || taken),
        .start  (id_ex_muldiv),
        .is_div (id_ex_is_div),
        .busy   (md_busy),
        .done   (md_done),
        .idle   (md_idle)
    );

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        redirect     = 1'b0;
        muldiv_busy  = 1'b0;
        muldiv_done  = 1'b0;
        stall_evt    = 1'b0;
        if (!rst) begin
            if (taken) begin
                redirect     = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (md_busy) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_flush = 1'b1;
                muldiv_busy  = 1'b1;
                stall_evt    = 1'b1;
            end else begin
                muldiv_done = md_done;
                // Load-use only checked when no mul/div is in flight.
                if (md_idle && lu_hazard) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                    stall_evt   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_evt && !(&stall_q)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (taken && !(&flush_q)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    // {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush, redirect, busy, done}
    localparam logic [8:0] C_RUN = 9'b111_000_000;
    localparam logic [8:0] C_LU  = 9'b001_010_000;
    localparam logic [8:0] C_MD  = 9'b000_001_010;
    localparam logic [8:0] C_DN  = 9'b111_000_001;
    localparam logic [8:0] C_RED = 9'b111_111_100;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, id_ex_wn;
    logic       id_uses_rt, id_ex_mem_read, id_ex_muldiv, id_ex_is_div;
    logic       ex_mem_branch, ex_mem_zero, ex_mem_jal;

    logic        pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush;
    logic        redirect, muldiv_busy, muldiv_done;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_en, s_if_id_en, s_id_ex_en, s_if_id_flush, s_id_ex_flush, s_ex_mem_flush;
    logic        s_redirect, s_muldiv_busy, s_muldiv_done;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_wn(id_ex_wn), .id_ex_muldiv(id_ex_muldiv),
        .id_ex_is_div(id_ex_is_div), .ex_mem_branch(ex_mem_branch), .ex_mem_zero(ex_mem_zero),
        .ex_mem_jal(ex_mem_jal), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .redirect(redirect), .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow-counter copy so flush_cnt saturation is reachable in few cycles.
    pipe_hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_wn(id_ex_wn), .id_ex_muldiv(id_ex_muldiv),
        .id_ex_is_div(id_ex_is_div), .ex_mem_branch(ex_mem_branch), .ex_mem_zero(ex_mem_zero),
        .ex_mem_jal(ex_mem_jal), .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en),
        .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
        .ex_mem_flush(s_ex_mem_flush), .redirect(s_redirect), .muldiv_busy(s_muldiv_busy),
        .muldiv_done(s_muldiv_done), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct {
        logic [8:0] ctrl;
        string      tag;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [15:0] exp_stall = '0;
    logic [15:0] exp_flush = '0;
    logic        cnt_known = 1'b0;

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Push expectation, sample mid-cycle, pop and compare, then advance the model.
    task automatic step(input logic [8:0] ectrl, input string tag);
        exp_t        e;
        logic [8:0]  obs;
        sb.push_back('{ctrl: ectrl, tag: tag});
        @(negedge clk);
        e   = sb.pop_front();
        obs = {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush,
               redirect, muldiv_busy, muldiv_done};
        n_chk++;
        assert (obs === e.ctrl) n_pass++;
        else begin
            $display("FAIL %s ctrl observed=%b expected=%b", e.tag, obs, e.ctrl);
            $error("check %s", e.tag);
        end
        if (cnt_known) begin
            check16({e.tag, "_stall_cnt"}, stall_cnt, exp_stall);
            check16({e.tag, "_flush_cnt"}, flush_cnt, exp_flush);
        end
        if (rst) begin
            exp_stall = '0;
            exp_flush = '0;
            cnt_known = 1'b1;
        end else begin
            if (!e.ctrl[8] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
            if (e.ctrl[2] && exp_flush != 16'hFFFF) exp_flush = exp_flush + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b1;
        id_ex_mem_read = 1'b0; id_ex_wn = 5'd0;
        id_ex_muldiv = 1'b0; id_ex_is_div = 1'b0;
        ex_mem_branch = 1'b0; ex_mem_zero = 1'b0; ex_mem_jal = 1'b0;
    endtask

    initial begin
        idle_inputs();
        // Hazards present during reset must be masked.
        rst = 1'b1; id_ex_muldiv = 1'b1; ex_mem_jal = 1'b1;
        step(C_RUN, "reset0");
        step(C_RUN, "reset1");
        rst = 1'b0; idle_inputs();
        step(C_RUN, "idle");

        id_ex_mem_read = 1'b1; id_ex_wn = 5'd5; id_rs = 5'd5;
        step(C_LU, "lu_rs");
        idle_inputs();
        step(C_RUN, "lu_after");
        id_ex_mem_read = 1'b1; id_ex_wn = 5'd0; id_rs = 5'd0;
        step(C_RUN, "lu_r0");
        id_ex_wn = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b0;
        step(C_RUN, "lu_rt_unused");
        id_uses_rt = 1'b1;
        step(C_LU, "lu_rt");
        idle_inputs();

        id_ex_muldiv = 1'b1; id_ex_is_div = 1'b0;
        for (int i = 0; i < 3; i++) step(C_MD, "mul_busy");
        step(C_DN, "mul_done");
        idle_inputs();
        step(C_RUN, "mul_after");

        id_ex_muldiv = 1'b1; id_ex_is_div = 1'b1;
        for (int i = 0; i < 31; i++) step(C_MD, "div_busy");
        step(C_DN, "div_done");
        idle_inputs();

        id_ex_muldiv = 1'b1; id_ex_is_div = 1'b1;
        for (int i = 0; i < 9; i++) step(C_MD, "div2_busy");
        ex_mem_branch = 1'b1; ex_mem_zero = 1'b1;
        step(C_RED, "div_abort");
        // Sequencer must be back in IDLE: load-use is honoured, no done pulse.
        idle_inputs();
        id_ex_mem_read = 1'b1; id_ex_wn = 5'd9; id_rs = 5'd9;
        step(C_LU, "post_abort_lu");

        ex_mem_jal = 1'b1;
        step(C_RED, "jal_over_lu");
        idle_inputs();
        ex_mem_branch = 1'b1; ex_mem_zero = 1'b0;
        step(C_RUN, "br_not_taken");
        idle_inputs();

        id_ex_muldiv = 1'b1; id_ex_is_div = 1'b1;
        step(C_MD, "rst_mid_start");
        step(C_MD, "rst_mid_busy");
        rst = 1'b1;
        step(C_RUN, "rst_in_busy");
        rst = 1'b0; id_ex_muldiv = 1'b0;
        step(C_RUN, "after_rst_busy");

        // Load-use held far beyond 2^16 cycles: both stall counters pin at all-ones.
        id_ex_mem_read = 1'b1; id_ex_wn = 5'd3; id_rs = 5'd3;
        repeat (66000) @(posedge clk);
        #1;
        exp_stall = 16'hFFFF;
        step(C_LU, "stall_sat");
        check16("small_stall_sat", {12'd0, s_stall_cnt}, 16'h000F);
        idle_inputs();

        ex_mem_jal = 1'b1;
        for (int i = 0; i < 20; i++) step(C_RED, "jal_burst");
        idle_inputs();
        step(C_RUN, "after_burst");
        check16("small_flush_sat", {12'd0, s_flush_cnt}, 16'h000F);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
